// File: rtl/layer_sequencer.sv
//------------------------------------------------------------------------------
// layer_sequencer
//
// Control FSM for one neural-network layer job on an N_MACS-wide MAC array.
// A job runs through these steps:
//   - clear the accumulators
//   - load n_rows weight rows
//   - stream n_vecs input vectors
//   - wait DRAIN_CYC cycles for the MAC pipeline to empty
//   - read out the N_MACS accumulators one beat at a time
//   - pulse done
//
// Ports:
//   clk_i        : single clock, rising-edge active
//   rst_i        : synchronous active-high reset
//   start_i      : begin a job (only honoured in IDLE)
//   abort_i      : synchronous cancel of the running job
//   n_rows_i     : weight rows to load, captured when start is accepted
//   n_vecs_i     : input vectors to stream, captured when start is accepted
//   w_valid_i    : weight-row valid from the weight source
//   w_ready_o    : weight-row ready (LOAD only)
//   x_valid_i    : input-vector valid from the activation source
//   x_ready_o    : input-vector ready (STREAM only)
//   mode_o       : weight pipeline mode, 0 idle / 1 load / 2 layer
//   acc_clear_o  : one-cycle accumulator clear
//   rd_valid_o   : readout valid (READ only)
//   rd_ready_i   : readout ready from the consumer
//   rd_idx_o     : accumulator index being read out
//   busy_o       : high in every state except IDLE
//   done_o       : one-cycle job completion pulse
//------------------------------------------------------------------------------
module layer_sequencer #(
  parameter int  N_MACS    = 4,
  parameter int  DRAIN_CYC = 5,
  localparam int IDX_W     = (N_MACS > 1) ? $clog2(N_MACS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [7:0]       n_rows_i,
  input  logic [7:0]       n_vecs_i,
  input  logic             w_valid_i,
  output logic             w_ready_o,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  output logic [2:0]       mode_o,
  output logic             acc_clear_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [IDX_W-1:0] rd_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_MACS - 1);

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_LAYER = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_e;

  state_e             state_q,    state_d;
  logic [7:0]         rowCnt_q,   rowCnt_d;
  logic [7:0]         vecCnt_q,   vecCnt_d;
  logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;
  logic [IDX_W-1:0]   rdIdx_q,    rdIdx_d;
  logic [7:0]         nRows_q,    nRows_d;
  logic [7:0]         nVecs_q,    nVecs_d;

  // State and counter registers. Reset wins over everything, including a
  // start or abort presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rowCnt_q   <= '0;
      vecCnt_q   <= '0;
      drainCnt_q <= '0;
      rdIdx_q    <= '0;
      nRows_q    <= '0;
      nVecs_q    <= '0;
    end else begin
      state_q    <= state_d;
      rowCnt_q   <= rowCnt_d;
      vecCnt_q   <= vecCnt_d;
      drainCnt_q <= drainCnt_d;
      rdIdx_q    <= rdIdx_d;
      nRows_q    <= nRows_d;
      nVecs_q    <= nVecs_d;
    end
  end

  // Next-state and counter logic. Abort is checked before any handshake,
  // so a beat completing in the abort cycle is dropped rather than counted.
  // The row and vector counters stop at their terminal count (count+1 ==
  // target), which keeps them from wrapping even with a target of 255.
  always_comb begin
    state_d    = state_q;
    rowCnt_d   = rowCnt_q;
    vecCnt_d   = vecCnt_q;
    drainCnt_d = drainCnt_q;
    rdIdx_d    = rdIdx_q;
    nRows_d    = nRows_q;
    nVecs_d    = nVecs_q;

    if (abort_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      rowCnt_d   = '0;
      vecCnt_d   = '0;
      drainCnt_d = '0;
      rdIdx_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // abort in IDLE only serves to veto a simultaneous start
          if (start_i && !abort_i) begin
            nRows_d = n_rows_i;
            nVecs_d = n_vecs_i;
            state_d = S_CLEAR;
          end
        end

        S_CLEAR: begin
          rowCnt_d   = '0;
          vecCnt_d   = '0;
          drainCnt_d = '0;
          rdIdx_d    = '0;
          if (nRows_q != 8'd0) begin
            state_d = S_LOAD;
          end else if (nVecs_q != 8'd0) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_READ;
          end
        end

        S_LOAD: begin
          if (w_valid_i) begin
            rowCnt_d = rowCnt_q + 8'd1;
            if (rowCnt_q == nRows_q - 8'd1) begin
              state_d = (nVecs_q != 8'd0) ? S_STREAM : S_READ;
            end
          end
        end

        S_STREAM: begin
          if (x_valid_i) begin
            vecCnt_d = vecCnt_q + 8'd1;
            if (vecCnt_q == nVecs_q - 8'd1) begin
              drainCnt_d = '0;
              state_d    = (DRAIN_CYC > 0) ? S_DRAIN : S_READ;
            end
          end
        end

        S_DRAIN: begin
          if (drainCnt_q == DRAIN_LAST) begin
            drainCnt_d = '0;
            state_d    = S_READ;
          end else begin
            drainCnt_d = drainCnt_q + DRAIN_W'(1);
          end
        end

        S_READ: begin
          // rd_idx only moves on an accepted beat, so a stalled consumer
          // sees the same index until it takes it
          if (rd_ready_i) begin
            if (rdIdx_q == IDX_LAST) begin
              rdIdx_d = '0;
              state_d = S_DONE;
            end else begin
              rdIdx_d = rdIdx_q + IDX_W'(1);
            end
          end
        end

        S_DONE: begin
          rowCnt_d   = '0;
          vecCnt_d   = '0;
          drainCnt_d = '0;
          rdIdx_d    = '0;
          state_d    = S_IDLE;
        end

        default: begin
          state_d    = S_IDLE;
          rowCnt_d   = '0;
          vecCnt_d   = '0;
          drainCnt_d = '0;
          rdIdx_d    = '0;
        end
      endcase
    end
  end

  // Output decode, purely from the registered state and counters so that
  // no input can reach an output combinationally.
  always_comb begin
    mode_o      = MODE_IDLE;
    w_ready_o   = 1'b0;
    x_ready_o   = 1'b0;
    acc_clear_o = 1'b0;
    rd_valid_o  = 1'b0;
    rd_idx_o    = rdIdx_q;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;

    unique case (state_q)
      S_CLEAR: acc_clear_o = 1'b1;
      S_LOAD: begin
        mode_o    = MODE_LOAD;
        w_ready_o = 1'b1;
      end
      S_STREAM: x_ready_o = 1'b1;
      S_READ: begin
        mode_o     = MODE_LAYER;
        rd_valid_o = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer_sequencer.sv
//------------------------------------------------------------------------------
// tb_layer_sequencer
//
// Directed testbench for layer_sequencer. Each job's expected events are
// queued up front, using hand-computed busy-cycle numbers. Cycle 1 is the
// CLEAR cycle. The queued events are:
//   - acc_clear
//   - each weight beat
//   - each vector beat
//   - each readout beat with its index
//   - the done pulse
// A negedge monitor pops that queue whenever the DUT shows an event.
//------------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int N_MACS    = 4;
  localparam int DRAIN_CYC = 5;

  localparam int EV_CLR  = 0;
  localparam int EV_W    = 1;
  localparam int EV_X    = 2;
  localparam int EV_RD   = 3;
  localparam int EV_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] nRows = 8'd0;
  logic [7:0] nVecs = 8'd0;
  logic       wValid = 1'b0;
  logic       wReady;
  logic       xValid = 1'b0;
  logic       xReady;
  logic [2:0] mode;
  logic       accClear;
  logic       rdValid;
  logic       rdReady = 1'b1;
  logic [1:0] rdIdx;
  logic       busy;
  logic       done;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;

  ev_t expQ[$];
  int  checks   = 0;
  int  failures = 0;
  int  busyCyc  = 0;
  bit  monEn    = 1'b0;

  layer_sequencer #(.N_MACS(N_MACS), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .n_rows_i    (nRows),
    .n_vecs_i    (nVecs),
    .w_valid_i   (wValid),
    .w_ready_o   (wReady),
    .x_valid_i   (xValid),
    .x_ready_o   (xReady),
    .mode_o      (mode),
    .acc_clear_o (accClear),
    .rd_valid_o  (rdValid),
    .rd_ready_i  (rdReady),
    .rd_idx_o    (rdIdx),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input int kind, input int idx, input int cyc);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = cyc;
    expQ.push_back(e);
  endtask

  task automatic observe(input int kind, input int idx, input int cyc);
    ev_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL sb_unexpected kind=%0d idx=%0d cyc=%0d expected=none", kind, idx, cyc);
    end else begin
      e = expQ.pop_front();
      checkOutput($sformatf("sb_kind@cyc%0d", cyc), kind, e.kind);
      checkOutput($sformatf("sb_idx@cyc%0d", cyc), idx, e.idx);
      checkOutput($sformatf("sb_cyc_kind%0d", kind), cyc, e.cyc);
    end
  endtask

  // Monitor: tracks the busy-cycle number, checks the mode/ready decode
  // rules every cycle and reports each presented event to the scoreboard.
  // Beats offered while abort or rst is high are never counted by the DUT.
  always @(negedge clk) begin
    int expMode;
    if (monEn) begin
      busyCyc = busy ? busyCyc + 1 : 0;
      expMode = wReady ? 1 : (rdValid ? 2 : 0);
      checkOutput("modeDecode", mode, expMode);
      checkOutput("readyExcl", (int'(wReady) + int'(xReady) + int'(rdValid)) > 1, 0);
      if (accClear) observe(EV_CLR, 0, busyCyc);
      if (wValid && wReady && !abort && !rst) observe(EV_W, 0, busyCyc);
      if (xValid && xReady && !abort && !rst) observe(EV_X, 0, busyCyc);
      if (rdValid && rdReady && !abort && !rst) observe(EV_RD, int'(rdIdx), busyCyc);
      if (done) observe(EV_DONE, 0, busyCyc);
    end
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_mode"}, mode, 0);
    checkOutput({tag, "_wReady"}, wReady, 0);
    checkOutput({tag, "_xReady"}, xReady, 0);
    checkOutput({tag, "_accClear"}, accClear, 0);
    checkOutput({tag, "_rdValid"}, rdValid, 0);
    checkOutput({tag, "_rdIdx"}, rdIdx, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Drives one job. Cycle 0 presents start; cycle k (k >= 1) is the k-th
  // cycle after the start edge. Inputs change 1 time unit after each edge.
  task automatic applyStimulus(input string tag, input int rows, input int vecs,
                               input bit wToggle, input int stallAt, input int stallLen,
                               input int abortAt, input int rstAt,
                               input int startA, input int startB,
                               input int idleFrom, input int nCyc);
    @(posedge clk); #1;
    start  = 1'b1;
    nRows  = 8'(rows);
    nVecs  = 8'(vecs);
    abort  = 1'b0;
    rst    = 1'b0;
    wValid = 1'b1;
    xValid = 1'b1;
    rdReady = 1'b1;
    for (int k = 1; k <= nCyc; k++) begin
      @(posedge clk); #1;
      // changing the size inputs after acceptance must not affect the job
      nRows   = 8'(rows + 5);
      nVecs   = 8'(vecs + 5);
      start   = (k == startA) || (k == startB) || (k == rstAt && rstAt != 0);
      wValid  = wToggle ? ((k % 2) == 0) : 1'b1;
      xValid  = 1'b1;
      rdReady = !(stallAt != 0 && k >= stallAt && k < stallAt + stallLen);
      abort   = (abortAt != 0 && k == abortAt);
      rst     = (rstAt != 0 && k == rstAt);
      if (idleFrom != 0 && k >= idleFrom) checkIdle($sformatf("%s_idle_k%0d", tag, k));
    end
    @(posedge clk); #1;
    start   = 1'b0;
    abort   = 1'b0;
    rst     = 1'b0;
    wValid  = 1'b0;
    xValid  = 1'b0;
    rdReady = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_sbEmpty"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic expectNominal(input int doneCyc);
    expectEvent(EV_CLR, 0, 1);
    for (int i = 0; i < 3; i++) expectEvent(EV_W, 0, 2 + i);
    for (int i = 0; i < 2; i++) expectEvent(EV_X, 0, 5 + i);
    for (int i = 0; i < N_MACS; i++) expectEvent(EV_RD, i, 12 + i);
    expectEvent(EV_DONE, 0, doneCyc);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    checkIdle("rst");
    rst = 1'b0;
    monEn = 1'b1;
    @(posedge clk); #1;
    checkIdle("postRst");

    // nominal job: 3 rows, 2 vectors, everything ready; busy for 16 cycles
    expectNominal(16);
    applyStimulus("nominal", 3, 2, 1'b0, 0, 0, 0, 0, 0, 0, 17, 18);

    // start pulses during LOAD (cycle 3) and READ (cycle 13) change nothing
    expectNominal(16);
    applyStimulus("startMid", 3, 2, 1'b0, 0, 0, 0, 0, 3, 13, 17, 20);

    // w_valid toggles 1,0,1,0,1 over LOAD: rows at 2,4,6, done 2 cycles later
    expectEvent(EV_CLR, 0, 1);
    expectEvent(EV_W, 0, 2);
    expectEvent(EV_W, 0, 4);
    expectEvent(EV_W, 0, 6);
    expectEvent(EV_X, 0, 7);
    expectEvent(EV_X, 0, 8);
    for (int i = 0; i < N_MACS; i++) expectEvent(EV_RD, i, 14 + i);
    expectEvent(EV_DONE, 0, 18);
    applyStimulus("wToggle", 3, 2, 1'b1, 0, 0, 0, 0, 0, 0, 19, 20);

    // rd_ready low for 2 cycles at rd_idx=1: idx 1 held, done at 18
    expectEvent(EV_CLR, 0, 1);
    for (int i = 0; i < 3; i++) expectEvent(EV_W, 0, 2 + i);
    for (int i = 0; i < 2; i++) expectEvent(EV_X, 0, 5 + i);
    expectEvent(EV_RD, 0, 12);
    expectEvent(EV_RD, 1, 15);
    expectEvent(EV_RD, 2, 16);
    expectEvent(EV_RD, 3, 17);
    expectEvent(EV_DONE, 0, 18);
    applyStimulus("rdStall", 3, 2, 1'b0, 13, 2, 0, 0, 0, 0, 19, 20);

    // zero counts: CLEAR straight to READ
    expectEvent(EV_CLR, 0, 1);
    for (int i = 0; i < N_MACS; i++) expectEvent(EV_RD, i, 2 + i);
    expectEvent(EV_DONE, 0, 6);
    applyStimulus("zero", 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 7, 8);

    // abort on the 2nd STREAM beat (cycle 6): beat dropped, idle from 7
    expectEvent(EV_CLR, 0, 1);
    for (int i = 0; i < 3; i++) expectEvent(EV_W, 0, 2 + i);
    expectEvent(EV_X, 0, 5);
    applyStimulus("abort", 3, 2, 1'b0, 0, 0, 6, 0, 0, 0, 7, 10);

    // following 1-row, 1-vector job completes normally
    expectEvent(EV_CLR, 0, 1);
    expectEvent(EV_W, 0, 2);
    expectEvent(EV_X, 0, 3);
    for (int i = 0; i < N_MACS; i++) expectEvent(EV_RD, i, 9 + i);
    expectEvent(EV_DONE, 0, 13);
    applyStimulus("afterAbort", 1, 1, 1'b0, 0, 0, 0, 0, 0, 0, 14, 15);

    // reset after one row beat, with start in the same cycle
    expectEvent(EV_CLR, 0, 1);
    expectEvent(EV_W, 0, 2);
    applyStimulus("rstLoad", 3, 2, 1'b0, 0, 0, 0, 3, 0, 0, 4, 8);

    // start together with abort in IDLE: job not accepted
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    nRows = 8'd3;
    nVecs = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkIdle("startAbortIdle");
    @(posedge clk); #1;
    checkIdle("startAbortIdle2");
    checkOutput("finalSbEmpty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
